// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the EX-stage operand muxes.
// Keeps its own EX/MEM/WB shadow of destination registers and control bits.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rt_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_AW-1:0] ex_rs_r, ex_rt_r, ex_rd_r;
    logic              ex_rw_r, ex_mr_r;
    logic [REG_AW-1:0] mem_rd_r, wb_rd_r;
    logic              mem_rw_r, wb_rw_r;
    logic [1:0]        fwd_a_r, fwd_b_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              stall_s;
    logic [REG_AW-1:0] ex_rs_s, ex_rt_s, ex_rd_s;
    logic              ex_rw_s, ex_mr_s;
    logic [1:0]        fwd_a_s, fwd_b_s;

    // EX/MEM beats MEM/WB; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              m_rw,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_rw,
        input logic [REG_AW-1:0] w_rd
    );
        if (m_rw && (m_rd != REG_ZERO) && (m_rd == src)) begin
            return 2'b01;
        end else if (w_rw && (w_rd != REG_ZERO) && (w_rd == src)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    // Load-use detection against the load currently in EX; a flush overrides it.
    always_comb begin
        stall_s = 1'b0;
        if (ex_mr_r && (ex_rd_r != REG_ZERO) && !flush_i &&
            ((ex_rd_r == id_rs_i) || (id_rt_used_i && (ex_rd_r == id_rt_i)))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next EX contents: the ID instruction, or a bubble on stall/flush.
    always_comb begin
        ex_rs_s = REG_ZERO;
        ex_rt_s = REG_ZERO;
        ex_rd_s = REG_ZERO;
        ex_rw_s = 1'b0;
        ex_mr_s = 1'b0;
        if (stall_s || flush_i) begin
            ex_rs_s = REG_ZERO;
            ex_rt_s = REG_ZERO;
            ex_rd_s = REG_ZERO;
            ex_rw_s = 1'b0;
            ex_mr_s = 1'b0;
        end else begin
            ex_rs_s = id_rs_i;
            ex_rt_s = id_rt_i;
            ex_rd_s = id_rd_i;
            ex_rw_s = id_regwrite_i;
            ex_mr_s = id_memread_i;
        end
    end

    // Selects are computed from next-cycle shadow state so the outputs come straight from flops.
    always_comb begin
        fwd_a_s = fwd_sel(ex_rs_s, ex_rw_r, ex_rd_r, mem_rw_r, mem_rd_r);
        fwd_b_s = fwd_sel(ex_rt_s, ex_rw_r, ex_rd_r, mem_rw_r, mem_rd_r);
    end

    // Shadow pipeline, registered selects and saturating stall counter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_rs_r     <= REG_ZERO;
            ex_rt_r     <= REG_ZERO;
            ex_rd_r     <= REG_ZERO;
            ex_rw_r     <= 1'b0;
            ex_mr_r     <= 1'b0;
            mem_rd_r    <= REG_ZERO;
            mem_rw_r    <= 1'b0;
            wb_rd_r     <= REG_ZERO;
            wb_rw_r     <= 1'b0;
            fwd_a_r     <= 2'b00;
            fwd_b_r     <= 2'b00;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            ex_rs_r  <= ex_rs_s;
            ex_rt_r  <= ex_rt_s;
            ex_rd_r  <= ex_rd_s;
            ex_rw_r  <= ex_rw_s;
            ex_mr_r  <= ex_mr_s;
            mem_rd_r <= ex_rd_r;
            mem_rw_r <= ex_rw_r;
            wb_rd_r  <= mem_rd_r;
            wb_rw_r  <= mem_rw_r;
            fwd_a_r  <= fwd_a_s;
            fwd_b_r  <= fwd_b_s;
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign forward_a_o = fwd_a_r;
    assign forward_b_o = fwd_b_r;
    assign stall_o     = stall_s;
    assign stall_cnt_o = stall_cnt_r;

endmodule
